dmac_cmd_sequencer: RTL and testbench

Hardware command sequencer that programs the cluster DMA through one of its peripheral control ports. It is used in place of software by an accelerator or the event unit. It accepts transfer descriptors over a valid/ready interface and runs the fixed DMA programming protocol: TID allocation, command, TCDM address and external address writes. It then polls the status register until the transfer completes, frees the TID, and reports completion with the TID.

---
 rtl/dmac_cmd_sequencer.sv | 260 ++++++++++++++++++++++++++
 tb/tb_dmac_cmd_sequencer.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_cmd_sequencer.sv
// dmac_cmd_sequencer
// Runs the cluster DMA programming sequence from a transfer descriptor:
// allocate a TID, write the command, TCDM address and external address,
// poll status until the TID clears, free the TID and report completion.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | ready for a descriptor
// TID_RD     | read command register, capture allocated TID
// CMD_WR     | write command word (len, dir, incremental)
// LOC_WR     | write TCDM address
// EXT_WR     | write external address
// POLL_RD    | read status register, test the TID bit
// POLL_WAIT  | idle gap between status polls
// FREE_WR    | write TID mask to status register to release the TID
// DONE       | one-cycle completion pulse
//
// Every bus state has a REQ phase (req_q=1, waiting for gnt) and a RESP
// phase (req_q=0, waiting for r_valid); req_q itself marks the phase.
module dmac_cmd_sequencer #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h1020_4400,
    parameter logic [ADDR_WIDTH-1:0] CMD_OFFSET    = 32'h0,
    parameter logic [ADDR_WIDTH-1:0] STATUS_OFFSET = 32'h4,
    parameter int                    LEN_WIDTH     = 17,
    parameter int                    TID_WIDTH     = 4,
    parameter int                    POLL_GAP      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    desc_valid_i,
    output logic                    desc_ready_o,
    input  logic [LEN_WIDTH-1:0]    desc_len_i,
    input  logic                    desc_dir_i,
    input  logic [31:0]             desc_loc_addr_i,
    input  logic [31:0]             desc_ext_addr_i,
    output logic                    ctrl_req_o,
    output logic [ADDR_WIDTH-1:0]   ctrl_add_o,
    output logic                    ctrl_wen_o,
    output logic [DATA_WIDTH/8-1:0] ctrl_be_o,
    output logic [DATA_WIDTH-1:0]   ctrl_wdata_o,
    input  logic                    ctrl_gnt_i,
    input  logic                    ctrl_r_valid_i,
    input  logic [DATA_WIDTH-1:0]   ctrl_r_rdata_i,
    input  logic                    ctrl_r_opc_i,
    output logic                    done_o,
    output logic [TID_WIDTH-1:0]    done_tid_o,
    output logic                    err_o,
    output logic                    busy_o
);

    localparam logic [ADDR_WIDTH-1:0] CMD_ADDR    = BASE_ADDR + CMD_OFFSET;
    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = BASE_ADDR + STATUS_OFFSET;
    localparam int                    CNT_W       = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CNT_W-1:0]      CNT_LOAD    = CNT_W'(POLL_GAP - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TID_RD,
        ST_CMD_WR,
        ST_LOC_WR,
        ST_EXT_WR,
        ST_POLL_RD,
        ST_POLL_WAIT,
        ST_FREE_WR,
        ST_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic                    req_q, req_d;
    logic [ADDR_WIDTH-1:0]   add_q, add_d;
    logic                    wen_q, wen_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    done_q, done_d;
    logic [TID_WIDTH-1:0]    done_tid_q, done_tid_d;
    logic                    err_q, err_d;
    logic [TID_WIDTH-1:0]    tid_q, tid_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic                    dir_q, dir_d;
    logic [31:0]             loc_q, loc_d;
    logic [31:0]             ext_q, ext_d;

    logic [DATA_WIDTH-1:0]   cmd_word;
    logic [DATA_WIDTH-1:0]   tid_mask;
    logic                    tid_busy;

    // Command word layout and the one-hot TID mask used for poll and free
    always_comb begin
        cmd_word                = '0;
        cmd_word[LEN_WIDTH-1:0] = len_q;
        cmd_word[LEN_WIDTH]     = dir_q;
        cmd_word[LEN_WIDTH+1]   = 1'b1;
        tid_mask                = DATA_WIDTH'(1) << tid_q;
        tid_busy                = |(ctrl_r_rdata_i & tid_mask);
    end

    // Next-state and next-output logic of the sequencer
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        add_d      = add_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        done_d     = 1'b0;
        done_tid_d = done_tid_q;
        err_d      = 1'b0;
        tid_d      = tid_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        dir_d      = dir_q;
        loc_d      = loc_q;
        ext_d      = ext_q;

        unique case (state_q)
            ST_IDLE: begin
                if (desc_valid_i) begin
                    len_d   = desc_len_i;
                    dir_d   = desc_dir_i;
                    loc_d   = desc_loc_addr_i;
                    ext_d   = desc_ext_addr_i;
                    state_d = ST_TID_RD;
                    req_d   = 1'b1;
                    add_d   = CMD_ADDR;
                    wen_d   = 1'b1;
                    wdata_d = '0;
                end
            end

            ST_POLL_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_POLL_RD;
                    req_d   = 1'b1;
                    add_d   = STATUS_ADDR;
                    wen_d   = 1'b1;
                    wdata_d = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                if (req_q) begin
                    // r_valid cannot belong to this access before the grant
                    if (ctrl_gnt_i) begin
                        req_d = 1'b0;
                    end
                end else if (ctrl_r_valid_i) begin
                    if (ctrl_r_opc_i) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        case (state_q)
                            ST_TID_RD: begin
                                tid_d   = ctrl_r_rdata_i[TID_WIDTH-1:0];
                                state_d = ST_CMD_WR;
                                req_d   = 1'b1;
                                add_d   = CMD_ADDR;
                                wen_d   = 1'b0;
                                wdata_d = cmd_word;
                            end
                            ST_CMD_WR: begin
                                state_d = ST_LOC_WR;
                                req_d   = 1'b1;
                                add_d   = CMD_ADDR;
                                wen_d   = 1'b0;
                                wdata_d = DATA_WIDTH'(loc_q);
                            end
                            ST_LOC_WR: begin
                                state_d = ST_EXT_WR;
                                req_d   = 1'b1;
                                add_d   = CMD_ADDR;
                                wen_d   = 1'b0;
                                wdata_d = DATA_WIDTH'(ext_q);
                            end
                            ST_EXT_WR: begin
                                state_d = ST_POLL_RD;
                                req_d   = 1'b1;
                                add_d   = STATUS_ADDR;
                                wen_d   = 1'b1;
                                wdata_d = '0;
                            end
                            ST_POLL_RD: begin
                                if (tid_busy) begin
                                    state_d = ST_POLL_WAIT;
                                    cnt_d   = CNT_LOAD;
                                end else begin
                                    state_d = ST_FREE_WR;
                                    req_d   = 1'b1;
                                    add_d   = STATUS_ADDR;
                                    wen_d   = 1'b0;
                                    wdata_d = tid_mask;
                                end
                            end
                            ST_FREE_WR: begin
                                state_d    = ST_DONE;
                                done_d     = 1'b1;
                                done_tid_d = tid_q;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    // State and registered outputs; reset drops any access in flight
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            add_q      <= '0;
            wen_q      <= 1'b1;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            done_tid_q <= '0;
            err_q      <= 1'b0;
            tid_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            dir_q      <= 1'b0;
            loc_q      <= '0;
            ext_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            add_q      <= add_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            done_tid_q <= done_tid_d;
            err_q      <= err_d;
            tid_q      <= tid_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            dir_q      <= dir_d;
            loc_q      <= loc_d;
            ext_q      <= ext_d;
        end
    end

    assign desc_ready_o = (state_q == ST_IDLE) && !rst_i;
    assign busy_o       = (state_q != ST_IDLE);
    assign ctrl_req_o   = req_q;
    assign ctrl_add_o   = add_q;
    assign ctrl_wen_o   = wen_q;
    assign ctrl_be_o    = '1;
    assign ctrl_wdata_o = wdata_q;
    assign done_o       = done_q;
    assign done_tid_o   = done_tid_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_dmac_cmd_sequencer.sv
// Bench for dmac_cmd_sequencer: a control-bus slave with random grant and
// response delays, a descriptor-level model of the expected access list,
// and directed plus random transfers.
module tb_dmac_cmd_sequencer;

    localparam logic [31:0] CMD_A  = 32'h1020_4400;
    localparam logic [31:0] STAT_A = 32'h1020_4404;
    localparam int          P      = 4;

    typedef struct {
        logic [16:0] len;
        logic        dir;
        logic [31:0] loc;
        logic [31:0] ext;
    } desc_t;

    typedef struct {
        logic        wen;
        logic [31:0] add;
        logic [31:0] wdata;
        int          req_cyc;
        int          gnt_cyc;
    } acc_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        desc_valid_i;
    logic        desc_ready_o;
    logic [16:0] desc_len_i;
    logic        desc_dir_i;
    logic [31:0] desc_loc_addr_i;
    logic [31:0] desc_ext_addr_i;
    logic        ctrl_req_o;
    logic [31:0] ctrl_add_o;
    logic        ctrl_wen_o;
    logic [3:0]  ctrl_be_o;
    logic [31:0] ctrl_wdata_o;
    logic        ctrl_gnt_i;
    logic        ctrl_r_valid_i;
    logic [31:0] ctrl_r_rdata_i;
    logic        ctrl_r_opc_i;
    logic        done_o;
    logic [3:0]  done_tid_o;
    logic        err_o;
    logic        busy_o;

    dmac_cmd_sequencer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .desc_valid_i    (desc_valid_i),
        .desc_ready_o    (desc_ready_o),
        .desc_len_i      (desc_len_i),
        .desc_dir_i      (desc_dir_i),
        .desc_loc_addr_i (desc_loc_addr_i),
        .desc_ext_addr_i (desc_ext_addr_i),
        .ctrl_req_o      (ctrl_req_o),
        .ctrl_add_o      (ctrl_add_o),
        .ctrl_wen_o      (ctrl_wen_o),
        .ctrl_be_o       (ctrl_be_o),
        .ctrl_wdata_o    (ctrl_wdata_o),
        .ctrl_gnt_i      (ctrl_gnt_i),
        .ctrl_r_valid_i  (ctrl_r_valid_i),
        .ctrl_r_rdata_i  (ctrl_r_rdata_i),
        .ctrl_r_opc_i    (ctrl_r_opc_i),
        .done_o          (done_o),
        .done_tid_o      (done_tid_o),
        .err_o           (err_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // slave configuration and bookkeeping
    int          gnt_max   = 0;
    int          r_max     = 0;
    int          err_at    = -1;
    int          hold_at   = -1;
    int          acc_count = 0;
    bit          holding   = 0;
    bit          stray_rv  = 0;
    int          proto_err = 0;
    int          stab_err  = 0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    logic [3:0]  tid_rq[$];
    logic [31:0] stat_q[$];
    acc_t        obs_q[$];
    acc_t        exp_q[$];

    bit          in_req = 0;
    bit          outstanding = 0;
    int          g_wait = 0;
    int          r_wait = 0;
    acc_t        cur;
    logic [31:0] resp_data;
    logic        resp_opc;

    // Control-bus slave: drives gnt / response at the falling edge
    always @(negedge clk_i) begin
        ctrl_gnt_i     = 1'b0;
        ctrl_r_valid_i = 1'b0;
        ctrl_r_opc_i   = 1'b0;
        ctrl_r_rdata_i = $urandom();
        if (done_o) done_cnt++;
        if (err_o) err_cnt++;
        if (done_o && desc_valid_i && desc_ready_o) proto_err++;
        if (rst_i) begin
            in_req      = 0;
            outstanding = 0;
            holding     = 0;
        end else if (outstanding) begin
            if (ctrl_req_o) proto_err++;
            if (r_wait == 0) begin
                ctrl_r_valid_i = 1'b1;
                ctrl_r_rdata_i = resp_data;
                ctrl_r_opc_i   = resp_opc;
                outstanding    = 0;
            end else begin
                r_wait--;
            end
        end else if (ctrl_req_o) begin
            if (!in_req) begin
                in_req      = 1;
                cur.wen     = ctrl_wen_o;
                cur.add     = ctrl_add_o;
                cur.wdata   = ctrl_wdata_o;
                cur.req_cyc = cyc;
                g_wait      = $urandom_range(gnt_max, 0);
            end else if (ctrl_add_o !== cur.add || ctrl_wen_o !== cur.wen ||
                         ctrl_wdata_o !== cur.wdata) begin
                stab_err++;
            end
            if (ctrl_be_o !== 4'hF) proto_err++;
            if (acc_count == hold_at) begin
                holding = 1;
            end else if (g_wait == 0) begin
                ctrl_gnt_i  = 1'b1;
                in_req      = 0;
                outstanding = 1;
                r_wait      = $urandom_range(r_max, 0);
                cur.gnt_cyc = cyc;
                obs_q.push_back(cur);
                resp_opc    = (acc_count == err_at);
                acc_count++;
                if (cur.wen && cur.add == CMD_A) begin
                    logic [3:0] t;
                    t = (tid_rq.size() > 0) ? tid_rq.pop_front() : 4'd0;
                    resp_data = ($urandom() & 32'hFFFF_FFF0) | 32'(t);
                end else if (cur.wen && cur.add == STAT_A) begin
                    resp_data = (stat_q.size() > 0) ? stat_q.pop_front() : 32'h0;
                end else begin
                    resp_data = $urandom();
                end
            end else begin
                g_wait--;
            end
        end
        if (stray_rv) begin
            ctrl_r_valid_i = 1'b1;
            ctrl_r_opc_i   = 1'b1;
            stray_rv       = 0;
        end
    end

    // Reference model: the access list one descriptor must produce
    task automatic build_exp(input desc_t d, input logic [3:0] tid, input int npolls);
        logic [31:0] cmd;
        cmd = 32'(d.len) + (32'(d.dir) << 17) + (32'h1 << 18);
        exp_q.push_back('{1'b1, CMD_A, 32'h0, 0, 0});
        exp_q.push_back('{1'b0, CMD_A, cmd, 0, 0});
        exp_q.push_back('{1'b0, CMD_A, d.loc, 0, 0});
        exp_q.push_back('{1'b0, CMD_A, d.ext, 0, 0});
        repeat (npolls) exp_q.push_back('{1'b1, STAT_A, 32'h0, 0, 0});
        exp_q.push_back('{1'b0, STAT_A, 32'h1 << tid, 0, 0});
    endtask

    task automatic prep(input logic [3:0] tid, input int nbusy);
        tid_rq.push_back(tid);
        repeat (nbusy) stat_q.push_back($urandom() | (32'h1 << tid));
        stat_q.push_back($urandom() & ~(32'h1 << tid));
    endtask

    task automatic clear_scn();
        obs_q.delete();
        exp_q.delete();
        tid_rq.delete();
        stat_q.delete();
        acc_count = 0;
        err_at    = -1;
        hold_at   = -1;
        holding   = 0;
        stab_err  = 0;
        proto_err = 0;
    endtask

    task automatic cmp_accesses(input string tag);
        int prev;
        chk({tag, "_nacc"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            chk({tag, "_wen"}, obs_q[i].wen, exp_q[i].wen);
            chk({tag, "_add"}, obs_q[i].add, exp_q[i].add);
            if (!exp_q[i].wen) chk({tag, "_wdata"}, obs_q[i].wdata, exp_q[i].wdata);
        end
        prev = -1;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (obs_q[i].wen && obs_q[i].add == STAT_A) begin
                if (prev >= 0)
                    chk({tag, "_pollgap"},
                        (obs_q[i].req_cyc - obs_q[prev].gnt_cyc - 1) >= P + 1, 1'b1);
                prev = i;
            end
        end
        chk({tag, "_stable"}, stab_err, 0);
        chk({tag, "_proto"}, proto_err, 0);
    endtask

    function automatic desc_t rand_desc();
        desc_t d;
        d.len = 17'($urandom());
        d.dir = 1'($urandom_range(1, 0));
        d.loc = $urandom();
        d.ext = $urandom();
        return d;
    endfunction

    task automatic drive_desc(input desc_t d);
        desc_len_i      = d.len;
        desc_dir_i      = d.dir;
        desc_loc_addr_i = d.loc;
        desc_ext_addr_i = d.ext;
    endtask

    // Present a descriptor; lat counts edges from the accepting edge to done/err.
    // With chain set, the next descriptor is driven and valid stays high.
    task automatic send_desc(input desc_t d, input bit chain, input desc_t nxt,
                             output int rdy_wait, output int lat,
                             output bit got_done, output bit got_err);
        drive_desc(d);
        desc_valid_i = 1'b1;
        rdy_wait = 0;
        while (!desc_ready_o && rdy_wait < 200) begin
            @(posedge clk_i); #1;
            rdy_wait++;
        end
        if (rdy_wait >= 200) chk("ready_timeout", desc_ready_o, 1'b1);
        lat = 0;
        do begin
            @(posedge clk_i); #1;
            lat++;
            if (lat == 1) begin
                if (chain) drive_desc(nxt);
                else desc_valid_i = 1'b0;
            end
        end while (!done_o && !err_o && lat < 3000);
        got_done = done_o;
        got_err  = err_o;
    endtask

    desc_t d0, d1;
    int    rw, lat, n;
    bit    gd, ge;
    int    dc0, ec0;
    logic [3:0] t0;
    int    nb;

    initial begin
        rst_i          = 1'b1;
        desc_valid_i   = 1'b0;
        desc_len_i     = '0;
        desc_dir_i     = 1'b0;
        desc_loc_addr_i = '0;
        desc_ext_addr_i = '0;
        ctrl_gnt_i     = 1'b0;
        ctrl_r_valid_i = 1'b0;
        ctrl_r_rdata_i = '0;
        ctrl_r_opc_i   = 1'b0;

        // reset values, ready held low while reset is asserted
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req", ctrl_req_o, 1'b0);
        chk("rst_wen", ctrl_wen_o, 1'b1);
        chk("rst_add", ctrl_add_o, 32'h0);
        chk("rst_wdata", ctrl_wdata_o, 32'h0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_done_tid", done_tid_o, 4'h0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_ready", desc_ready_o, 1'b0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("idle_ready", desc_ready_o, 1'b1);

        // single transfer at minimum latency
        clear_scn();
        d0 = '{17'h100, 1'b1, 32'h1000_0040, 32'h1C00_8000};
        tid_rq.push_back(4'd3);
        stat_q.push_back(32'h0);
        build_exp(d0, 4'd3, 1);
        send_desc(d0, 0, d0, rw, lat, gd, ge);
        chk("single_done", gd, 1'b1);
        chk("single_lat", lat, 13);
        chk("single_tid", done_tid_o, 4'd3);
        chk("single_busy_in_done", busy_o, 1'b1);
        @(posedge clk_i); #1;
        chk("single_done_pulse", done_o, 1'b0);
        chk("single_ready_after", desc_ready_o, 1'b1);
        chk("single_tid_hold", done_tid_o, 4'd3);
        cmp_accesses("single");

        // polling: two busy replies then clear
        clear_scn();
        d0 = rand_desc();
        prep(4'd5, 2);
        build_exp(d0, 4'd5, 3);
        send_desc(d0, 0, d0, rw, lat, gd, ge);
        chk("poll_done", gd, 1'b1);
        chk("poll_lat", lat, 13 + 2 * (P + 2));
        chk("poll_tid", done_tid_o, 4'd5);
        cmp_accesses("poll");

        // random transfers with grant and response backpressure
        gnt_max = 7;
        r_max   = 3;
        for (int k = 0; k < 8; k++) begin
            clear_scn();
            d0 = rand_desc();
            t0 = 4'($urandom_range(15, 0));
            nb = $urandom_range(2, 0);
            prep(t0, nb);
            build_exp(d0, t0, nb + 1);
            send_desc(d0, 0, d0, rw, lat, gd, ge);
            chk("bp_done", gd, 1'b1);
            chk("bp_tid", done_tid_o, t0);
            cmp_accesses("bp");
            @(posedge clk_i); #1;
        end
        gnt_max = 0;
        r_max   = 0;

        // error response on the TCDM address write
        clear_scn();
        err_at = 2;
        d0 = rand_desc();
        prep(4'd6, 0);
        dc0 = done_cnt;
        ec0 = err_cnt;
        send_desc(d0, 0, d0, rw, lat, gd, ge);
        chk("err_seen", ge, 1'b1);
        chk("err_no_done", gd, 1'b0);
        chk("err_busy", busy_o, 1'b0);
        @(posedge clk_i); #1;
        chk("err_pulse", err_o, 1'b0);
        repeat (20) @(posedge clk_i);
        #1;
        chk("err_nacc", obs_q.size(), 3);
        chk("err_done_cnt", done_cnt - dc0, 0);
        chk("err_err_cnt", err_cnt - ec0, 1);
        chk("err_req_idle", ctrl_req_o, 1'b0);

        // reset during the ungranted external-address write
        clear_scn();
        hold_at = 3;
        d0 = rand_desc();
        prep(4'd7, 0);
        drive_desc(d0);
        desc_valid_i = 1'b1;
        n = 0;
        while (!desc_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
        @(posedge clk_i); #1;
        desc_valid_i = 1'b0;
        n = 0;
        while (!holding && n < 200) begin @(posedge clk_i); #1; n++; end
        chk("rst_mid_reached", holding, 1'b1);
        chk("rst_mid_pre_wdata", ctrl_wdata_o, d0.ext);
        chk("rst_mid_pre_req", ctrl_req_o, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_mid_req", ctrl_req_o, 1'b0);
        chk("rst_mid_busy", busy_o, 1'b0);
        rst_i   = 1'b0;
        hold_at = -1;
        ec0     = err_cnt;
        stray_rv = 1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("stray_busy", busy_o, 1'b0);
        chk("stray_req", ctrl_req_o, 1'b0);
        chk("stray_err", err_cnt - ec0, 0);
        clear_scn();
        d0 = rand_desc();
        prep(4'd12, 1);
        build_exp(d0, 4'd12, 2);
        send_desc(d0, 0, d0, rw, lat, gd, ge);
        chk("post_rst_done", gd, 1'b1);
        chk("post_rst_tid", done_tid_o, 4'd12);
        cmp_accesses("post_rst");
        @(posedge clk_i); #1;

        // back-to-back descriptors with valid held
        clear_scn();
        d0 = rand_desc();
        d1 = rand_desc();
        prep(4'd2, 0);
        prep(4'd9, 1);
        build_exp(d0, 4'd2, 1);
        build_exp(d1, 4'd9, 2);
        send_desc(d0, 1, d1, rw, lat, gd, ge);
        chk("b2b_a_done", gd, 1'b1);
        chk("b2b_a_tid", done_tid_o, 4'd2);
        chk("b2b_ready_at_done", desc_ready_o, 1'b0);
        send_desc(d1, 0, d1, rw, lat, gd, ge);
        chk("b2b_ready_wait", rw, 1);
        chk("b2b_b_done", gd, 1'b1);
        chk("b2b_b_lat", lat, 13 + P + 2);
        chk("b2b_b_tid", done_tid_o, 4'd9);
        cmp_accesses("b2b");

        repeat (3) @(posedge clk_i);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
